// File: rtl/mux_arb_n.sv
// N-channel round-robin multiplexer/arbiter: locks onto one valid channel and forwards its beats
// until that channel drops valid or the optional burst limit forces a release. Optional drop counter: MUX_ARB_DROP_CNT_EN.
module mux_arb_n #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [CHANNELS-1:0]       grant,
  output logic                      busy
`ifdef MUX_ARB_DROP_CNT_EN
  ,
  output logic [15:0]               drop_count
`endif
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic [CHANNELS-1:0]  grant_q, grant_d;
  logic [7:0]           beat_q, beat_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     ptr_next;
  logic                 limit_hit;
  int                   cand;

  // Rotating priority search: first valid channel at or above ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = (int'(ptr_q) + k) % CHANNELS;
      if (!win_found && valid_in[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign ptr_next = (int'(win_idx) == CHANNELS - 1) ? '0 : win_idx + 1'b1;

  // beat_q counts beats after the grant beat, so the burst length so far is beat_q + 1.
  assign limit_hit = (MAX_BURST > 0) && ((int'(beat_q) + 1) >= MAX_BURST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    valid_d = 1'b0;
    grant_d = '0;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCK;
          owner_d = win_idx;
          ptr_d   = ptr_next;
          data_d  = data_in[win_idx*WIDTH +: WIDTH];
          valid_d = 1'b1;
          grant_d = {{(CHANNELS-1){1'b0}}, 1'b1} << win_idx;
          beat_d  = '0;
        end
      end
      LOCK: begin
        if (valid_in[owner_q] && !limit_hit) begin
          data_d  = data_in[owner_q*WIDTH +: WIDTH];
          valid_d = 1'b1;
          grant_d = grant_q;
          beat_d  = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q == LOCK);

`ifdef MUX_ARB_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  // grant_d is non-zero only for the channel actually forwarded this cycle.
  always_comb begin
    drop_d = drop_q;
    if (|(valid_in & ~grant_d) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width per channel in bits (1..64).
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of input channels (2..8).
REQ-003 The block SHALL have parameter MAX_BURST, default 0, meaning beats forwarded before a forced release (0 = unlimited, else 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port data_in, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port valid_in, input, CHANNELS bits: bit i qualifies channel i data.
REQ-008 The block SHALL have port data_out, output, WIDTH bits: registered forwarded data.
REQ-009 The block SHALL have port valid_out, output, 1 bit: registered; qualifies data_out.
REQ-010 The block SHALL have port grant, output, CHANNELS bits: registered one-hot locked channel; all zero when idle.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state LOCK.

Function
REQ-012 The FSM SHALL have two states: IDLE and LOCK.
REQ-013 In IDLE with any valid_in bit set, the block SHALL grant one channel and enter LOCK, with data_out = that channel's data and valid_out = 1 on the next edge (latency 1 cycle).
REQ-014 When several valid_in bits rise together in IDLE, the winner SHALL be the first set bit searching upward from priority pointer ptr, wrapping CHANNELS-1 -> 0.
REQ-015 On each grant, ptr SHALL become (granted index + 1) mod CHANNELS.
REQ-016 In LOCK with valid_in[granted] = 1, the block SHALL forward data_in[granted] with valid_out = 1 each cycle; other channels SHALL be ignored.
REQ-017 In LOCK with valid_in[granted] = 0, the block SHALL return to IDLE with valid_out = 0, grant = 0 on the next edge; other channels valid in that cycle SHALL NOT be granted.
REQ-018 With MAX_BURST = N > 0, after N beats the block SHALL force IDLE (valid_out = 0 next edge) even if valid_in[granted] stays high; re-arbitration then uses the updated ptr.
REQ-019 A channel that stays valid across a forced release SHALL be eligible again in IDLE like any other channel.
REQ-020 data_out SHALL hold its last value while valid_out = 0.
REQ-021 The beat counter SHALL be 8 bits, clear on grant, and never wrap within a burst.

Reset
REQ-022 With reset = 1 at a clock edge, the block SHALL set state = IDLE, ptr = 0, data_out = 0, valid_out = 0, grant = 0, busy = 0, beat counter = 0, and drop_count = 0 (if present).
REQ-023 Reset SHALL take priority over all inputs, including mid-burst; the first grant after reset release SHALL follow REQ-014 with ptr = 0.

Configuration
REQ-024 When macro MUX_ARB_DROP_CNT_EN is defined, the block SHALL add output drop_count (16 bits, registered), counting +1 per cycle in which at least one valid_in bit is set on a channel not forwarded that cycle, saturating at 16'hFFFF.
REQ-025 When MUX_ARB_DROP_CNT_EN is undefined, drop_count and its logic SHALL be absent, with all other behaviour identical.

Verification (WIDTH=8, CHANNELS=4, MAX_BURST=0 unless noted)
REQ-026 Test: reset 2 cycles, then valid_in=0001 with data ch0 FF,EE,DD and valid low after -> data_out FF,EE,DD with valid_out=1, then valid_out=0 and grant=0000.
REQ-027 Test: ch0 locked with AA; ch1 raises valid one cycle later with 33 -> 33 never appears on data_out; drop_count increments each overlap cycle.
REQ-028 Test: from reset, valid_in=1111 together, data 10/11/12/13, one beat per burst with one idle cycle between bursts, four bursts -> grants ch0, ch1, ch2, ch3 in order; data_out 10, 11, 12, 13.
REQ-029 Test: MAX_BURST=2, ch0 and ch2 held valid continuously -> ch0 forwards 2 beats, 1 idle cycle, ch2 forwards 2 beats, 1 idle cycle, repeating.
REQ-030 Test: reset asserted during the 3rd beat of a ch1 burst -> next edge valid_out=0, grant=0000, busy=0; after release a tie on 0011 grants ch0.
REQ-031 Test: hold ch1 valid unserved against a locked ch0 for 70000 cycles -> drop_count saturates at FFFF and does not wrap.
